// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

   localparam int SUB_N_DEFAULT = 4;
   localparam int SUB_CNT_W     = $clog2(SUB_N_DEFAULT + 1);

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_sub_full_adder_bit.sv
// One-bit full adder slice shared by every serial step.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial signed subtractor: S = X - Y, LSB first, n+1 result bits.
module serial_sub
   import sub_pkg::*;
#(
   parameter int n = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [n-1:0] X,
   input  logic signed [n-1:0] Y,
   output logic                busy,
   output logic                done,
   output logic signed [n:0]   S
);

   localparam int CW = cnt_width(n);
   localparam logic [CW-1:0] LAST = CW'(n);

   sub_state_t    state;
   logic [n:0]    a;
   logic [n:0]    b;
   logic [n:0]    acc;
   logic          carry;
   logic [CW-1:0] cnt;
   logic          sum;
   logic          cout;
   logic          accept;

   full_adder_bit u_fa (
      .a    (a[0]),
      .b    (b[0]),
      .cin  (carry),
      .s    (sum),
      .cout (cout)
   );

   // A request waiting on the DONE edge starts the next op, giving n+2 throughput
   assign accept = start & ((state == IDLE) | (state == DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a     <= '0;
         b     <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         S     <= '0;
      end else if (accept) begin
         a     <= {X[n-1], X};
         b     <= ~{Y[n-1], Y};
         carry <= 1'b1;
         cnt   <= '0;
         acc   <= '0;
         state <= SHIFT;
         busy  <= 1'b1;
         done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
            SHIFT: begin
               a     <= {1'b0, a[n:1]};
               b     <= {1'b0, b[n:1]};
               acc   <= {sum, acc[n:1]};
               carry <= cout;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  S     <= {sum, acc[n:1]};
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub with n = 4.
module tb_serial_sub;

   localparam int N = 4;

   typedef struct {
      int x;
      int y;
      int s;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic signed [N-1:0] X;
   logic signed [N-1:0] Y;
   logic                busy;
   logic                done;
   logic signed [N:0]   S;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   serial_sub #(.n(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .X     (X),
      .Y     (Y),
      .busy  (busy),
      .done  (done),
      .S     (S)
   );

   task automatic chk(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Pulse start for one cycle, then track latency and busy time.
   task automatic run_op(input int x, input int y, input bit scramble,
                         output int lat, output int bcnt, output int idle_ok);
      @(negedge clk);
      X = x[N-1:0];
      Y = y[N-1:0];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (scramble) begin
         X = N'($urandom);
         Y = N'($urandom);
      end
      lat = -1;
      bcnt = busy ? 1 : 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (busy) bcnt++;
         if (done) begin
            lat = i;
            break;
         end
      end
      @(posedge clk);
      #1;
      idle_ok = (!busy && !done) ? 1 : 0;
   endtask

   vec_t tbl[$];
   int   lat, bcnt, idle_ok;
   int   prev, ndone, dpos, stable;
   int   pulses[$];

   initial begin
      tbl = '{
         '{4, 3, 1}, '{-2, 5, -7}, '{-8, 7, -15}, '{7, -8, 15},
         '{0, 0, 0}, '{1, 1, 0}, '{-8, -8, 0}, '{7, 7, 0},
         '{-1, 7, -8}
      };

      rst = 1'b1;
      start = 1'b0;
      X = '0;
      Y = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_s", int'(S), 0);
      rst = 1'b0;

      foreach (tbl[k]) begin
         run_op(tbl[k].x, tbl[k].y, 1'b0, lat, bcnt, idle_ok);
         chk($sformatf("tbl%0d_s", k), int'(S), tbl[k].s);
         chk($sformatf("tbl%0d_lat", k), lat, 5);
         chk($sformatf("tbl%0d_busy", k), bcnt, 6);
         chk($sformatf("tbl%0d_idle", k), idle_ok, 1);
      end

      // Start while busy is dropped; S holds until completion.
      prev = int'(S);
      @(negedge clk);
      X = '0;
      Y = '0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ndone = 0;
      dpos = -1;
      stable = 1;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk);
         #1;
         if (i == 2) begin
            start = 1'b1;
            X = 4'sd3;
            Y = 4'sd1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            dpos = i;
            chk("ign_s", int'(S), 0);
         end else if (i < 5 && int'(S) != prev) begin
            stable = 0;
         end
      end
      chk("ign_ndone", ndone, 1);
      chk("ign_dpos", dpos, 5);
      chk("ign_stable", stable, 1);

      // Reset mid-operation.
      run_op(7, -8, 1'b0, lat, bcnt, idle_ok);
      chk("pre_rst_s", int'(S), 15);
      @(negedge clk);
      X = 4'sd5;
      Y = -4'sd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_s", int'(S), 0);
      rst = 1'b0;
      ndone = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("mid_rst_nodone", ndone, 0);
      run_op(1, 1, 1'b0, lat, bcnt, idle_ok);
      chk("post_rst_s", int'(S), 0);
      chk("post_rst_lat", lat, 5);

      // Start held high: done every n+2 cycles.
      @(negedge clk);
      X = 4'sd2;
      Y = 4'sd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 1; i <= 18; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses.push_back(i);
            chk("held_s", int'(S), 1);
         end
      end
      start = 1'b0;
      chk("held_npulse", pulses.size(), 3);
      if (pulses.size() == 3) begin
         chk("held_p0", pulses[0], 5);
         chk("held_p1", pulses[1], 11);
         chk("held_p2", pulses[2], 17);
      end
      repeat (10) @(posedge clk);
      #1;
      chk("held_idle", int'(busy), 0);

      // Random operands against plain integer subtraction.
      for (int r = 0; r < 40; r++) begin
         int xr, yr;
         xr = int'($urandom_range(0, 15));
         yr = int'($urandom_range(0, 15));
         if (xr >= 8) xr -= 16;
         if (yr >= 8) yr -= 16;
         run_op(xr, yr, 1'b1, lat, bcnt, idle_ok);
         chk($sformatf("rnd%0d_s(%0d-%0d)", r, xr, yr), int'(S), xr - yr);
         chk($sformatf("rnd%0d_lat", r), lat, 5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
